dsi_lane_rx: RTL and testbench

DSI_LANE_RX -- requirements
Module: dsi_lane_rx

---
 rtl/dsi_rx_pkg.sv | 28 ++
 rtl/dsi_rx_byte_aligner.sv | 55 +++++
 rtl/dsi_lane_rx.sv | 153 +++++++++++++++
 tb/tb_dsi_lane_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_rx_pkg.sv
// ============================================================================
// dsi_rx_pkg : shared states and line codes for the DSI data-lane receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package dsi_rx_pkg;

   typedef enum logic [2:0] {
      STATE_STOP        = 3'd0,
      STATE_HS_RQST     = 3'd1,
      STATE_BRIDGE      = 3'd2,
      STATE_SYNC_SEARCH = 3'd3,
      STATE_RX_ACTIVE   = 3'd4,
      STATE_EOT_FLUSH   = 3'd5,
      STATE_WAIT_STOP   = 3'd6
   } state_e;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   // LP line codes as {Dp, Dn}
   localparam logic [1:0] LP11 = 2'b11;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP00 = 2'b00;

endpackage

`default_nettype wire

// File: rtl/dsi_rx_byte_aligner.sv
// ============================================================================
// dsi_rx_byte_aligner : sync-byte search over a 16-bit window and barrel shift
// Rev 1.0
// ============================================================================
`default_nettype none

module dsi_rx_byte_aligner
   import dsi_rx_pkg::*;
(
   input  logic       clk_phy,
   input  logic       rst_n,
   input  logic       search_i,
   input  logic [7:0] hs_byte_i,
   output logic       match_o,
   output logic [7:0] byte_o
);

   logic [7:0]  prev_q;
   logic [2:0]  offset_q;
   logic [2:0]  offset_d;
   logic [2:0]  hit_k;
   logic [7:0]  hits;
   logic [15:0] window;

   // Older byte sits in the low half: bit 0 of prev_q is the earliest bit
   assign window = {hs_byte_i, prev_q};

   for (genvar k = 0; k < 8; k++) begin : g_cmp
      assign hits[k] = (window[k +: 8] == SYNC_BYTE);
   end

   always_comb begin
      hit_k = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (hits[k]) hit_k = 3'(k);
      end
   end

   assign match_o  = search_i & (|hits);
   assign offset_d = match_o ? hit_k : offset_q;
   assign byte_o   = window[offset_q +: 8];

   always_ff @(posedge clk_phy or negedge rst_n) begin
      if (!rst_n) begin
         prev_q   <= 8'd0;
         offset_q <= 3'd0;
      end else begin
         prev_q   <= hs_byte_i;
         offset_q <= offset_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dsi_lane_rx.sv
// ============================================================================
// dsi_lane_rx : DSI data-lane receiver (LP handshake, HS sync, byte output)
// Rev 1.0
// ============================================================================
`default_nettype none

module dsi_lane_rx
   import dsi_rx_pkg::*;
#(
   parameter int SYNC_TIMEOUT = 16,
   parameter int HS_SETTLE    = 4
) (
   input  logic       clk_phy,
   input  logic       rst_n,
   input  logic       lane_enable,
   input  logic       LP_p_input,
   input  logic       LP_n_input,
   input  logic [7:0] hs_lane_input,
   input  logic       out_fifo_full,
   output logic [8:0] out_fifo_data,
   output logic       out_fifo_write,
   output logic       hs_term_enable,
   output logic       rx_active,
   output logic       sot_error,
   output logic       overflow
);

   localparam int CNT_MAX = (SYNC_TIMEOUT > HS_SETTLE) ? SYNC_TIMEOUT : HS_SETTLE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [1:0]       lp_meta_q;
   logic [1:0]       lp_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_vld_q, hold_vld_d;
   logic             pend_q, pend_d;
   logic [8:0]       data_q, data_d;
   logic             ovf_q, ovf_d;
   logic             sot_err;
   logic             match;
   logic [7:0]       aligned;

   dsi_rx_byte_aligner u_aligner (
      .clk_phy   (clk_phy),
      .rst_n     (rst_n),
      .search_i  (state_q == STATE_SYNC_SEARCH),
      .hs_byte_i (hs_lane_input),
      .match_o   (match),
      .byte_o    (aligned)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      pend_d     = 1'b0;
      data_d     = data_q;
      sot_err    = 1'b0;
      case (state_q)
         STATE_STOP: begin
            cnt_d      = '0;
            hold_vld_d = 1'b0;
            if (lp_q == LP01) state_d = STATE_HS_RQST;
         end
         STATE_HS_RQST: begin
            cnt_d = '0;
            if (lp_q == LP00)      state_d = STATE_BRIDGE;
            else if (lp_q == LP11) state_d = STATE_STOP;
            else if (lp_q != LP01) state_d = STATE_WAIT_STOP;
         end
         STATE_BRIDGE: begin
            if (lp_q != LP00) begin
               state_d = STATE_WAIT_STOP;
            end else if (cnt_q == CNT_W'(HS_SETTLE - 1)) begin
               state_d = STATE_SYNC_SEARCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STATE_SYNC_SEARCH: begin
            if (match) begin
               state_d = STATE_RX_ACTIVE;
            end else if (cnt_q == CNT_W'(SYNC_TIMEOUT - 1)) begin
               sot_err = 1'b1;
               state_d = STATE_WAIT_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STATE_RX_ACTIVE: begin
            // The held byte leaves one cycle late so the final one can carry the last flag
            pend_d = hold_vld_q;
            if (lp_q == LP11) begin
               state_d    = STATE_EOT_FLUSH;
               data_d     = {1'b1, hold_q};
               hold_vld_d = 1'b0;
            end else begin
               if (hold_vld_q) data_d = {1'b0, hold_q};
               hold_d     = aligned;
               hold_vld_d = 1'b1;
            end
         end
         STATE_EOT_FLUSH: state_d = STATE_STOP;
         STATE_WAIT_STOP: if (lp_q == LP11) state_d = STATE_STOP;
         default:         state_d = STATE_STOP;
      endcase
      if (!lane_enable) begin
         state_d    = STATE_STOP;
         pend_d     = 1'b0;
         hold_vld_d = 1'b0;
         sot_err    = 1'b0;
      end
      ovf_d = ovf_q | (pend_q & out_fifo_full);
   end

   always_ff @(posedge clk_phy or negedge rst_n) begin
      if (!rst_n) begin
         lp_meta_q  <= 2'b11;
         lp_q       <= 2'b11;
         state_q    <= STATE_STOP;
         cnt_q      <= '0;
         hold_q     <= 8'd0;
         hold_vld_q <= 1'b0;
         pend_q     <= 1'b0;
         data_q     <= 9'd0;
         ovf_q      <= 1'b0;
      end else begin
         lp_meta_q  <= {LP_p_input, LP_n_input};
         lp_q       <= lp_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         pend_q     <= pend_d;
         data_q     <= data_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_fifo_data  = data_q;
   assign out_fifo_write = pend_q & ~out_fifo_full;
   assign overflow       = ovf_q;
   assign sot_error      = sot_err;
   assign hs_term_enable = (state_q == STATE_BRIDGE) || (state_q == STATE_SYNC_SEARCH) ||
                           (state_q == STATE_RX_ACTIVE);
   assign rx_active      = (state_q == STATE_RX_ACTIVE) || (state_q == STATE_EOT_FLUSH);

endmodule

`default_nettype wire

// File: tb/tb_dsi_lane_rx.sv
// ============================================================================
// tb_dsi_lane_rx : randomized bit-stream packets against a payload-level model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dsi_lane_rx;
   import dsi_rx_pkg::*;

   localparam int SYNC_TIMEOUT = 16;
   localparam int HS_SETTLE    = 4;

   logic       clk_phy = 1'b0;
   logic       rst_n = 1'b0;
   logic       lane_enable = 1'b1;
   logic       LP_p_input = 1'b1;
   logic       LP_n_input = 1'b1;
   logic [7:0] hs_lane_input = 8'd0;
   logic       out_fifo_full = 1'b0;
   logic [8:0] out_fifo_data;
   logic       out_fifo_write;
   logic       hs_term_enable;
   logic       rx_active;
   logic       sot_error;
   logic       overflow;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] pay [16];
   logic [8:0] wq [$];
   logic       exp_ovf = 1'b0;

   always #5 clk_phy = ~clk_phy;

   dsi_lane_rx #(.SYNC_TIMEOUT(SYNC_TIMEOUT), .HS_SETTLE(HS_SETTLE)) dut (
      .clk_phy        (clk_phy),
      .rst_n          (rst_n),
      .lane_enable    (lane_enable),
      .LP_p_input     (LP_p_input),
      .LP_n_input     (LP_n_input),
      .hs_lane_input  (hs_lane_input),
      .out_fifo_full  (out_fifo_full),
      .out_fifo_data  (out_fifo_data),
      .out_fifo_write (out_fifo_write),
      .hs_term_enable (hs_term_enable),
      .rx_active      (rx_active),
      .sot_error      (sot_error),
      .overflow       (overflow)
   );

   always @(negedge clk_phy) if (out_fifo_write) wq.push_back(out_fifo_data);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_phy);
      #1;
   endtask

   task automatic set_lp(input logic [1:0] v);
      LP_p_input = v[1];
      LP_n_input = v[0];
   endtask

   task automatic idle(input int nc);
      set_lp(LP11);
      lane_enable   = 1'b1;
      out_fifo_full = 1'b0;
      hs_lane_input = 8'd0;
      repeat (nc) step();
   endtask

   // mode 0: normal end, 1: lane_enable dropped at cycle cut, 2: reset at cycle cut.
   // Cycle 0 is the first cycle LP-00 is driven; byte j of the bit stream is driven in cycle j.
   task automatic run_packet(input int mode, input int k, input int n, input int drop, input int cut);
      logic [255:0] stream;
      logic [8:0]   exp_q [$];
      int           wc;
      bit           reached;
      stream = '0;
      stream[64 + k +: 8] = SYNC_BYTE;
      for (int i = 0; i < n; i++) stream[72 + k + 8*i +: 8] = pay[i];
      for (int b = 72 + k + 8*n; b < 256; b++) stream[b] = 1'($urandom_range(0, 1));
      wq.delete();
      idle(4);
      set_lp(LP01);
      repeat (4) step();
      for (int c = 0; c <= n + 14; c++) begin
         hs_lane_input = stream[8*c +: 8];
         set_lp((c < n + 8) ? LP00 : LP11);
         out_fifo_full = (c == 12 + drop);
         if (mode == 1 && c == cut) lane_enable = 1'b0;
         if (mode == 2 && c == cut) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_write", 32'(out_fifo_write), 32'd0);
            check_eq("rst_data", 32'(out_fifo_data), 32'd0);
            check_eq("rst_rx_active", 32'(rx_active), 32'd0);
            check_eq("rst_hs_term", 32'(hs_term_enable), 32'd0);
            check_eq("rst_overflow", 32'(overflow), 32'd0);
            break;
         end
         @(negedge clk_phy);
         check_eq("hs_term", 32'(hs_term_enable), 32'(c >= 3 && c <= n + 10));
         check_eq("rx_active", 32'(rx_active), 32'(c >= 10 && c <= n + 11));
         check_eq("sot_idle", 32'(sot_error), 32'd0);
         step();
         if (mode == 1 && c == cut) begin
            @(negedge clk_phy);
            check_eq("cut_hs_term", 32'(hs_term_enable), 32'd0);
            check_eq("cut_rx_active", 32'(rx_active), 32'd0);
            step();
            break;
         end
      end
      if (mode == 2) begin
         repeat (2) step();
         rst_n = 1'b1;
      end
      idle(4);
      // Payload byte i is written 12+i cycles after LP-00 starts; a full FIFO then drops it
      for (int i = 0; i < n; i++) begin
         wc = 12 + i;
         reached = (mode == 0) || (mode == 1 && wc <= cut) || (mode == 2 && wc < cut);
         if (reached) begin
            if (i == drop) exp_ovf = 1'b1;
            else exp_q.push_back({(mode == 0 && i == n - 1), pay[i]});
         end
      end
      if (mode == 2) exp_ovf = 1'b0;
      check_eq("wr_count", 32'(wq.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
         check_eq("wr_data", 32'(wq[i]), 32'(exp_q[i]));
      check_eq("overflow", 32'(overflow), 32'(exp_ovf));
   endtask

   initial begin
      int sot_cnt, sot_cyc, mode, n, cut;
      logic seen;
      repeat (3) step();
      check_eq("reset_write", 32'(out_fifo_write), 32'd0);
      check_eq("reset_data", 32'(out_fifo_data), 32'd0);
      check_eq("reset_hs_term", 32'(hs_term_enable), 32'd0);
      check_eq("reset_rx_active", 32'(rx_active), 32'd0);
      check_eq("reset_sot", 32'(sot_error), 32'd0);
      check_eq("reset_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      idle(3);

      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      run_packet(0, 3, 3, 99, 0);
      check_eq("basic_w0", 32'(wq[0]), 32'h011);
      check_eq("basic_w1", 32'(wq[1]), 32'h022);
      check_eq("basic_w2", 32'(wq[2]), 32'h133);

      run_packet(0, 3, 3, 1, 0);
      check_eq("full_w0", 32'(wq[0]), 32'h011);
      check_eq("full_w1", 32'(wq[1]), 32'h133);
      check_eq("full_ovf", 32'(overflow), 32'd1);
      run_packet(0, 5, 3, 99, 0);

      // Sync never arrives
      wq.delete();
      idle(4);
      set_lp(LP01);
      repeat (4) step();
      sot_cnt = 0;
      sot_cyc = -1;
      for (int c = 0; c < 30; c++) begin
         set_lp(LP00);
         @(negedge clk_phy);
         if (sot_error) begin
            sot_cnt++;
            sot_cyc = c;
         end
         step();
      end
      check_eq("sot_count", 32'(sot_cnt), 32'd1);
      check_eq("sot_cycle", 32'(sot_cyc), 32'(2 + 1 + HS_SETTLE + SYNC_TIMEOUT - 1));
      check_eq("sot_nowrite", 32'(wq.size()), 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 14; c++) begin
         set_lp((c < 4) ? LP01 : LP00);
         @(negedge clk_phy);
         seen = seen | hs_term_enable;
         step();
      end
      check_eq("waitstop_hold", 32'(seen), 32'd0);
      idle(4);

      // LP-01 glitches to LP-10 during the HS request
      set_lp(LP01);
      repeat (4) step();
      seen = 1'b0;
      for (int c = 0; c < 13; c++) begin
         set_lp((c < 3) ? 2'b10 : LP00);
         @(negedge clk_phy);
         seen = seen | hs_term_enable;
         step();
      end
      check_eq("glitch_hs_term", 32'(seen), 32'd0);
      idle(4);

      for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
      run_packet(1, 2, 4, 99, 13);
      run_packet(2, 6, 4, 99, 12);
      run_packet(0, 0, 4, 99, 0);

      for (int it = 0; it < 24; it++) begin
         for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
         mode = $urandom_range(0, 3);
         if (mode == 3) mode = 0;
         n = $urandom_range((mode == 1) ? 2 : 1, 8);
         cut = (mode == 1) ? $urandom_range(11, n + 9) : $urandom_range(10, n + 10);
         run_packet(mode, $urandom_range(0, 7), n, $urandom_range(0, n + 3), cut);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
